lab3_mem_line_word_adapter: RTL
===============================

Name: lab3_mem_line_word_adapter

Overview:
- Downstream of the blocking cache's memory port.
- Converts each 16B line request (refill read, evict write, or init) into four sequential 4B word transactions to a word-wide memory.
- Gathers the four word responses into a single 16B line response.
- Lets the cache run against narrow memories or word-wide network endpoints without changing the cache's refill/evict FSM.

Parameters:
- p_max_inflight, 4, maximum word requests issued but not yet answered; legal range 1..4. A value of 1 fully serializes the four beats.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- linereq_msg  input  mem_req_16B_t  line request from the cache (type, opaque, addr, len, data[127:0])
- linereq_val  input  1  line request valid
- linereq_rdy  output  1  line request ready
- lineresp_msg  output  mem_resp_16B_t  line response to the cache
- lineresp_val  output  1  line response valid
- lineresp_rdy  input  1  line response ready
- wordreq_msg  output  mem_req_4B_t  word request to memory
- wordreq_val  output  1  word request valid
- wordreq_rdy  input  1  word request ready
- wordresp_msg  input  mem_resp_4B_t  word response from memory
- wordresp_val  input  1  word response valid
- wordresp_rdy  output  1  word response ready

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; req_cnt, resp_cnt, assembled data and captured fields cleared.
  - Outputs: linereq_rdy=0 during the reset cycle and 1 the cycle after; lineresp_val=0, wordreq_val=0, wordresp_rdy=0.
- FSM states IDLE, XFER, RESP.
- IDLE:
  - linereq_rdy=1.
  - On linereq_val&&rdy, capture type, opaque, line base addr = {addr[31:4],4'b0} (addr[3:0] ignored), and data.
  - Clear counters, go to XFER.
- XFER:
  - linereq_rdy=0, wordresp_rdy=1.
  - wordreq_val=1 while req_cnt<4 and (req_cnt-resp_cnt)<p_max_inflight.
  - wordreq_msg fields:
    - type = captured type (READ/WRITE/INIT passed through).
    - opaque = {6'b0, req_cnt[1:0]}.
    - addr = base + 4*req_cnt.
    - len = 0 (full 4B).
    - data = captured data[32*req_cnt +: 32] for WRITE/INIT, 0 for READ.
  - req_cnt increments on wordreq_val&&rdy.
  - Word responses are returned in order; each wordresp_val&&rdy writes data into slot resp_cnt[1:0] on READ (ignored for WRITE/INIT) and increments resp_cnt.
  - Issue and response in the same cycle are both counted; the inflight check uses registered counters.
  - When a response fires with resp_cnt==3, go to RESP next cycle.
- RESP:
  - lineresp_val=1, linereq_rdy=0, wordreq_val=0, wordresp_rdy=0.
  - lineresp_msg: type = captured type, opaque = captured opaque, test=0, len=0, data = assembled 128 bits for READ, 0 otherwise.
  - Message is held stable until lineresp_val&&rdy, then go to IDLE.
  - A new line request is accepted at the earliest the cycle after the handshake; no bypass.
- Latency: line accepted in cycle N → beat 0 request in N+1. With 1-cycle memory and always-ready, p_max_inflight=4: beats issued N+1..N+4, responses N+2..N+5, lineresp_val in N+6.
- Boundary conditions:
  - wordreq_rdy low stalls with msg stable.
  - lineresp_rdy low holds RESP indefinitely.
  - wordresp_val outside XFER is not accepted (rdy=0).
  - req_cnt saturates at 4.
  - Address wraps modulo 2^32 (base 0xFFFFFFF0 → beat 3 at 0xFFFFFFFC).
- Reset mid-operation: immediate return to IDLE and all in-progress state discarded. The memory side must be reset in the same cycle; stale word responses are not tracked.
- Opaque: word opaque fields are never used to reorder responses; memory must return in order.

Test Plan:
- READ refill: line read addr 0x00001007, opaque 0x5A, memory words at 0x1000..0x100C = 0x11,0x22,0x33,0x44 → word reads at 0x1000,0x1004,0x1008,0x100C; lineresp type READ, opaque 0x5A, data 0x00000044_00000033_00000022_00000011, 6 cycles after accept.
- WRITE evict: line write addr 0x2000, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → word writes 0xAAAAAAAA@0x2000 … 0xDDDDDDDD@0x200C in order; one WRITE lineresp with data 0.
- Backpressure: wordreq_rdy toggling 1,0,0,1… and lineresp_rdy low 5 cycles → no duplicated or dropped beats, wordreq_msg stable while stalled, lineresp held 5 cycles then accepted; linereq_rdy stays 0 throughout.
- Inflight limit p_max_inflight=1 with 3-cycle memory latency → never more than 1 outstanding; beat k+1 issued only after response k; READ data correct.
- Wrap/INIT: INIT at 0xFFFFFFF0 → beat addresses 0xFFFFFFF0,F4,F8,FC; lineresp type INIT.
- Reset during XFER after 2 beats → next cycle all outputs idle values, linereq_rdy=1; a subsequent READ completes correctly.

Source files
------------

// File: rtl/lab3_mem_line_word_adapter.sv
//==============================================================================
// lab3_mem_line_word_adapter
//
// Sits between the blocking cache's 16B memory port and a 4B word-wide memory.
// Each line request (READ refill, WRITE evict, INIT) becomes four word
// transactions to consecutive word addresses of the line. The four word
// responses are gathered back into a single line response. The cache's
// refill/evict FSM therefore does not need to know the memory is narrow.
//
// Parameters
//   p_max_inflight : word requests that may be issued but not yet answered
//                    (1..4). A value of 1 fully serializes the four beats.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   linereq_*      : 16B line request from the cache (val/rdy)
//   lineresp_*     : 16B line response to the cache (val/rdy)
//   wordreq_*      : 4B word request to memory (val/rdy)
//   wordresp_*     : 4B word response from memory (val/rdy, in order)
//==============================================================================

package lab3_mem_pkg;

   localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
   localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

   typedef struct packed {
      logic [2:0]   msg_type;
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic [2:0]   msg_type;
      logic [7:0]   opaque;
      logic [1:0]   test;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_resp_16B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

endpackage

module lab3_mem_line_word_adapter
   import lab3_mem_pkg::*;
#(
   parameter int p_max_inflight = 4
)(
   input  logic          clk,
   input  logic          reset,

   input  mem_req_16B_t  linereq_msg,
   input  logic          linereq_val,
   output logic          linereq_rdy,

   output mem_resp_16B_t lineresp_msg,
   output logic          lineresp_val,
   input  logic          lineresp_rdy,

   output mem_req_4B_t   wordreq_msg,
   output logic          wordreq_val,
   input  logic          wordreq_rdy,

   input  mem_resp_4B_t  wordresp_msg,
   input  logic          wordresp_val,
   output logic          wordresp_rdy
);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RESP
   } state_t;

   localparam logic [2:0] MaxInflight = 3'(p_max_inflight);

   state_t             state;
   state_t             state_next;

   logic [2:0]         req_cnt;
   logic [2:0]         resp_cnt;

   logic [2:0]         type_r;
   logic [7:0]         opaque_r;
   logic [31:0]        base_addr_r;
   logic [127:0]       line_data_r;
   logic [3:0][31:0]   resp_words_r;

   logic               is_read;
   logic               wordreq_fire;
   logic               wordresp_fire;

   // Bits of the incoming messages that the adapter deliberately ignores:
   // the line offset, the line length and the word response header fields.
   logic               unused_bits;
   assign unused_bits = ^{linereq_msg.addr[3:0], linereq_msg.len,
                          wordresp_msg.msg_type, wordresp_msg.opaque,
                          wordresp_msg.test, wordresp_msg.len};

   assign is_read       = (type_r == MEM_TYPE_READ);
   assign wordreq_fire  = wordreq_val && wordreq_rdy;
   assign wordresp_fire = wordresp_val && wordresp_rdy;

   // Holds the FSM state. Reset drops straight back to IDLE from anywhere,
   // abandoning whatever line was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. Every output is forced to its idle
   // value while reset is high so the cache sees linereq_rdy low during the
   // reset cycle itself. Word issue is throttled by comparing the registered
   // counters, so an issue and a response in the same cycle do not widen
   // the window until the following cycle.
   always_comb begin
      state_next   = state;
      linereq_rdy  = 1'b0;
      lineresp_val = 1'b0;
      wordreq_val  = 1'b0;
      wordresp_rdy = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               linereq_rdy = 1'b1;
               if (linereq_val) begin
                  state_next = XFER;
               end
            end
            XFER: begin
               wordresp_rdy = 1'b1;
               wordreq_val  = (req_cnt < 3'd4) &&
                              ((req_cnt - resp_cnt) < MaxInflight);
               if (wordresp_val && (resp_cnt == 3'd3)) begin
                  state_next = RESP;
               end
            end
            RESP: begin
               lineresp_val = 1'b1;
               if (lineresp_rdy) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Captures the line request header and payload when a line is accepted.
   // The low four address bits are dropped so beats always start on the
   // line boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         type_r      <= '0;
         opaque_r    <= '0;
         base_addr_r <= '0;
         line_data_r <= '0;
      end else if (linereq_val && linereq_rdy) begin
         type_r      <= linereq_msg.msg_type;
         opaque_r    <= linereq_msg.opaque;
         base_addr_r <= {linereq_msg.addr[31:4], 4'b0000};
         line_data_r <= linereq_msg.data;
      end
   end

   // Beat counters. req_cnt stops at 4 on its own because wordreq_val is
   // never raised once it gets there. Memory answers in order, so resp_cnt
   // doubles as the slot index for gathering read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_cnt      <= '0;
         resp_cnt     <= '0;
         resp_words_r <= '0;
      end else if (linereq_val && linereq_rdy) begin
         req_cnt  <= '0;
         resp_cnt <= '0;
      end else begin
         if (wordreq_fire) begin
            req_cnt <= req_cnt + 3'd1;
         end
         if (wordresp_fire) begin
            resp_cnt <= resp_cnt + 3'd1;
            if (is_read) begin
               resp_words_r[resp_cnt[1:0]] <= wordresp_msg.data;
            end
         end
      end
   end

   // Word request built from the captured line and the current beat.
   // The address add wraps naturally at 2^32. Read beats carry no data.
   always_comb begin
      wordreq_msg          = '0;
      wordreq_msg.msg_type = type_r;
      wordreq_msg.opaque   = {6'b000000, req_cnt[1:0]};
      wordreq_msg.addr     = base_addr_r + {27'd0, req_cnt, 2'b00};
      wordreq_msg.len      = 2'd0;
      wordreq_msg.data     = is_read ? 32'd0 : line_data_r[32*req_cnt[1:0] +: 32];
   end

   // Line response; only reads return the gathered words.
   always_comb begin
      lineresp_msg          = '0;
      lineresp_msg.msg_type = type_r;
      lineresp_msg.opaque   = opaque_r;
      lineresp_msg.test     = 2'd0;
      lineresp_msg.len      = 4'd0;
      lineresp_msg.data     = is_read ? resp_words_r : 128'd0;
   end

endmodule
